// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and address helper for the UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h3F;
    localparam logic [7:0] ADDR_MAX = 8'h0F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SEND,
        WAIT_DONE
    } cmd_state_e;

    function automatic logic addr_ok(input logic [7:0] addr);
        return addr <= ADDR_MAX;
    endfunction

endpackage

// File: rtl/cmd_regfile.sv
// 16 x 8-bit register file: one synchronous write port, one combinational read port, reg0 tap.
module cmd_regfile (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata,
    output logic [7:0] reg0
);

    logic [7:0] mem [16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign reg0  = mem[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-oriented command responder: 'W' addr data / 'R' addr, one response byte per frame.
// Optional inter-byte timeout in GET_ADDR/GET_DATA is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [7:0] reg0_out,
    output logic       busy,
    output logic       err_drop,
    output cmd_state_e dbg_state
);

    // Handshake: rx_done and tx_done are single-cycle strobes with no back-pressure;
    // tx_start is a single-cycle request and tx_data stays fixed until tx_done arrives.
    cmd_state_e state, next_state;
    logic       op_write, op_write_d;
    logic [7:0] addr, addr_d;
    logic [7:0] tx_data_d;
    logic       we;
    logic [7:0] rdata;
    logic       timeout_hit;

    cmd_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (addr[3:0]),
        .wdata (rx_data),
        .raddr (rx_data[3:0]),
        .rdata (rdata),
        .reg0  (reg0_out)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt;
    logic             in_frame;

    assign in_frame    = (state == GET_ADDR) || (state == GET_DATA);
    assign timeout_hit = in_frame && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      cnt <= '0;
        else if (rx_done || !in_frame)  cnt <= '0;
        else                            cnt <= cnt + CNT_W'(1);
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_write <= 1'b0;
            addr     <= 8'h00;
            tx_data  <= 8'h00;
            err_drop <= 1'b0;
        end else begin
            state    <= next_state;
            op_write <= op_write_d;
            addr     <= addr_d;
            tx_data  <= tx_data_d;
            err_drop <= rx_done && ((state == SEND) || (state == WAIT_DONE));
        end
    end

    always_comb begin
        next_state = state;
        op_write_d = op_write;
        addr_d     = addr;
        tx_data_d  = tx_data;
        we         = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done) begin
                    op_write_d = (rx_data == OP_WRITE);
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        next_state = GET_ADDR;
                    end else begin
                        next_state = SEND;
                        tx_data_d  = RESP_ERR;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_done) begin
                    addr_d = rx_data;
                    if (op_write) begin
                        next_state = GET_DATA;
                    end else begin
                        next_state = SEND;
                        tx_data_d  = addr_ok(rx_data) ? rdata : RESP_ERR;
                    end
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_done) begin
                    we         = addr_ok(addr);
                    tx_data_d  = addr_ok(addr) ? RESP_OK : RESP_ERR;
                    next_state = SEND;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            SEND:      next_state = WAIT_DONE;
            WAIT_DONE: if (tx_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    assign tx_start  = (state == SEND);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: command frames, bad opcodes/addresses, drops, timeout, reset.
module tb_uart_cmd_responder;
    import uart_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic [7:0] reg0_out;
    logic       busy;
    logic       err_drop;
    cmd_state_e dbg_state;

    int errors = 0;
    int checks = 0;
    int tx_cnt = 0;
    int err_cnt = 0;

`ifdef CMD_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 100000;
`endif

    uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .reg0_out  (reg0_out),
        .busy      (busy),
        .err_drop  (err_drop),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start === 1'b1) tx_cnt++;
        if (err_drop === 1'b1) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic run_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, output logic got, output logic [7:0] data,
                           output logic stable, output int pulses);
        int c0;
        logic [7:0] bytes [3];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        c0 = tx_cnt;
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
        got = 1'b0; data = 8'h00; stable = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (tx_start === 1'b1) begin
                got = 1'b1;
                data = tx_data;
            end else begin
                @(negedge clk);
            end
        end
        if (got) begin
            repeat (3) begin
                @(negedge clk);
                if (tx_data !== data) stable = 1'b0;
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        @(negedge clk);
        pulses = tx_cnt - c0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop got=%b exp=0", err_drop); end
        checks++; if (reg0_out !== 8'h00) begin errors++; $display("FAIL reset_reg0 got=%h exp=00", reg0_out); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic got, stable; logic [7:0] d; int p;
        run_cmd(3, 8'h57, 8'h03, 8'hA5, got, d, stable, p);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL write_tx_seen got=%b exp=1", got); end
        checks++; if (d !== 8'h4B) begin errors++; $display("FAIL write_resp got=%h exp=4b", d); end
        checks++; if (p !== 1) begin errors++; $display("FAIL write_pulses got=%0d exp=1", p); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL write_tx_stable got=%b exp=1", stable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_read;
        logic got, stable; logic [7:0] d; int p;
        run_cmd(2, 8'h52, 8'h03, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_reg3 got=%h exp=a5", d); end
        checks++; if (p !== 1) begin errors++; $display("FAIL read_pulses got=%0d exp=1", p); end
        run_cmd(3, 8'h57, 8'h00, 8'h5A, got, d, stable, p);
        checks++; if (d !== 8'h4B) begin errors++; $display("FAIL write0_resp got=%h exp=4b", d); end
        checks++; if (reg0_out !== 8'h5A) begin errors++; $display("FAIL write0_reg0 got=%h exp=5a", reg0_out); end
    endtask

    task automatic test_bad;
        logic got, stable; logic [7:0] d; int p;
        run_cmd(1, 8'h41, 8'h00, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'h3F) begin errors++; $display("FAIL bad_opcode_resp got=%h exp=3f", d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_opcode_busy got=%b exp=0", busy); end
        run_cmd(3, 8'h57, 8'h10, 8'h55, got, d, stable, p);
        checks++; if (d !== 8'h3F) begin errors++; $display("FAIL bad_waddr_resp got=%h exp=3f", d); end
        checks++; if (reg0_out !== 8'h5A) begin errors++; $display("FAIL bad_waddr_reg0 got=%h exp=5a", reg0_out); end
        run_cmd(2, 8'h52, 8'h13, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'h3F) begin errors++; $display("FAIL bad_raddr_resp got=%h exp=3f", d); end
        run_cmd(2, 8'h52, 8'h03, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL reg3_intact got=%h exp=a5", d); end
    endtask

    task automatic test_drop;
        int c_tx, c_err;
        c_tx = tx_cnt;
        c_err = err_cnt;
        send_byte(8'h41);
        @(negedge clk);
        rx_data = 8'h57; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", err_drop); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_still_wait got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got=%b exp=0", err_drop); end
        rx_data = 8'h52; rx_done = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; tx_done = 1'b0;
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_coincident got=%b exp=1", err_drop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_to_idle got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_not_opcode got=%b exp=0", busy); end
        checks++; if (err_cnt - c_err !== 2) begin errors++; $display("FAIL drop_count got=%0d exp=2", err_cnt - c_err); end
        checks++; if (tx_cnt - c_tx !== 1) begin errors++; $display("FAIL drop_tx_count got=%0d exp=1", tx_cnt - c_tx); end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        logic got, stable; logic [7:0] d; int p, c_tx;
        c_tx = tx_cnt;
        send_byte(8'h57);
        repeat (45) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early got=%b exp=1", busy); end
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got=%b exp=0", busy); end
        checks++; if (tx_cnt - c_tx !== 0) begin errors++; $display("FAIL timeout_no_tx got=%0d exp=0", tx_cnt - c_tx); end
        run_cmd(2, 8'h52, 8'h00, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL timeout_read0 got=%h exp=5a", d); end
    endtask
`endif

    task automatic test_reset_mid;
        logic got, stable; logic [7:0] d; int p, c_tx;
        send_byte(8'h57);
        send_byte(8'h03);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL mid_reset_err_drop got=%b exp=0", err_drop); end
        checks++; if (reg0_out !== 8'h00) begin errors++; $display("FAIL mid_reset_reg0 got=%h exp=00", reg0_out); end
        @(negedge clk);
        reset = 1'b0;
        c_tx = tx_cnt;
        repeat (5) @(negedge clk);
        checks++; if (tx_cnt - c_tx !== 0) begin errors++; $display("FAIL mid_reset_no_tx got=%0d exp=0", tx_cnt - c_tx); end
        run_cmd(2, 8'h52, 8'h03, 8'h00, got, d, stable, p);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_reg3 got=%h exp=00", d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad();
        test_drop();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 100000, clk cycles allowed between bytes of one command frame.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rx_data  input  8  byte from UART receiver; valid in the cycle rx_done=1.
REQ-005 SHALL have port: rx_done  input  1  one-cycle pulse, one received byte.
REQ-006 SHALL have port: tx_start  output  1  one-cycle request to UART transmitter.
REQ-007 SHALL have port: tx_data  output  8  response byte to transmitter.
REQ-008 SHALL have port: tx_done  input  1  one-cycle pulse, transmitter finished stop bit.
REQ-009 SHALL have port: reg0_out  output  8  live contents of register 0.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: err_drop  output  1  one-cycle pulse when a received byte is discarded.

Function
REQ-012 SHALL implement FSM states IDLE, GET_ADDR, GET_DATA, SEND, WAIT_DONE.
REQ-013 SHALL, in IDLE on rx_done, latch rx_data as opcode: 0x57 'W' -> GET_ADDR; 0x52 'R' -> GET_ADDR; other -> SEND with response 0x3F '?'.
REQ-014 SHALL, in GET_ADDR on rx_done, latch address: 'W' -> GET_DATA; 'R' -> SEND, response = reg[addr] if addr<=0x0F, else 0x3F.
REQ-015 SHALL, in GET_DATA on rx_done, if addr<=0x0F write rx_data to reg[addr] in that same cycle with response 0x4B 'K'; else no write, response 0x3F; then -> SEND.
REQ-016 SHALL, in SEND, assert tx_start for exactly one cycle with tx_data valid, then -> WAIT_DONE; tx_start rises the cycle after the final frame byte's rx_done.
REQ-017 SHALL hold tx_data stable from the tx_start cycle until tx_done is sampled.
REQ-018 SHALL, in WAIT_DONE on tx_done, -> IDLE; next command accepted from the following cycle.
REQ-019 SHALL, on rx_done in SEND or WAIT_DONE, discard the byte and pulse err_drop the next cycle; this includes rx_done coincident with tx_done.
REQ-020 SHALL provide 16 x 8-bit register file; address uses rx_data[7:0] compared against 0x0F, index bits [3:0].
REQ-021 SHALL drive reg0_out combinationally from reg[0], reflecting a write the cycle after the write.
REQ-022 SHALL ignore tx_done outside WAIT_DONE.

Reset
REQ-023 SHALL on reset: state IDLE, tx_start=0, tx_data=0x00, busy=0, err_drop=0, all registers 0x00 (reg0_out=0x00), timeout counter 0.
REQ-024 SHALL abort any frame or response immediately on mid-operation reset, with no further tx_start until a new command arrives.

Configuration
REQ-025 SHALL, with CMD_TIMEOUT_EN defined, count cycles in GET_ADDR/GET_DATA, clear the count on each rx_done, and at count TIMEOUT_CYCLES-1 return to IDLE with no response and no register write.
REQ-026 SHALL, without CMD_TIMEOUT_EN, omit the counter and wait indefinitely in GET_ADDR/GET_DATA.

Structure
REQ-027 SHALL place opcode constants (0x57, 0x52), response constants (0x4B, 0x3F), and FSM state encodings in shared package uart_cmd_pkg.
REQ-028 SHALL implement the register file as sub-module cmd_regfile: one write port, one combinational read port, reg0 tap.

Verification
REQ-029 SHALL cover: bytes 0x57,0x03,0xA5 -> reg[3]=0xA5, one tx_start with tx_data=0x4B, busy low after tx_done.
REQ-030 SHALL cover: after REQ-029, bytes 0x52,0x03 -> tx_data=0xA5; bytes 0x57,0x00,0x5A -> reg0_out=0x5A.
REQ-031 SHALL cover: byte 0x41 -> tx_data=0x3F; bytes 0x57,0x10,0x55 -> tx_data=0x3F, no register change.
REQ-032 SHALL cover: rx_done during WAIT_DONE, including the same cycle as tx_done -> err_drop pulse, FSM returns to IDLE, byte not treated as opcode.
REQ-033 SHALL cover (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=50): 0x57 then 60 idle cycles -> IDLE, no tx_start; then 0x52,0x00 -> tx_data=reg[0].
REQ-034 SHALL cover: reset asserted in GET_DATA -> all outputs at reset values, reg[3]=0x00 afterwards.
